// File: rtl/pipelined_merge_sorter.sv
// Bottom-up merge sorter for {key, index} entries, ping-ponging between two dual-port RAMs.
// Each round streams one merged entry per cycle; a key collision aborts the sort and raises fail.

module compare #(
    parameter int KW = 32
) (
    input  logic [KW-1:0] i_key_l,
    input  logic [KW-1:0] i_key_r,
    output logic          o_l_smaller,
    output logic          o_equal
);
    assign o_l_smaller = (i_key_l < i_key_r);
    assign o_equal     = (i_key_l == i_key_r);
endmodule

module mem_dual #(
    parameter int W     = 45,
    parameter int DEPTH = 8192,
    parameter int AW    = 13
) (
    input  logic          i_clk,
    input  logic          i_en0,
    input  logic          i_we0,
    input  logic [AW-1:0] i_addr0,
    input  logic [W-1:0]  i_wdata0,
    output logic [W-1:0]  o_q0,
    input  logic          i_en1,
    input  logic          i_we1,
    input  logic [AW-1:0] i_addr1,
    input  logic [W-1:0]  i_wdata1,
    output logic [W-1:0]  o_q1
);
    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_q0;
    logic [W-1:0] r_q1;

    // Reads see the pre-write contents when the same address is written this cycle.
    always_ff @(posedge i_clk) begin
        if (i_we0) r_mem[i_addr0] <= i_wdata0;
        if (i_we1) r_mem[i_addr1] <= i_wdata1;
        if (i_en0) r_q0 <= r_mem[i_addr0];
        if (i_en1) r_q1 <= r_mem[i_addr1];
    end

    assign o_q0 = r_q0;
    assign o_q1 = r_q1;
endmodule

module pipelined_merge_sorter #(
    parameter int INT_WIDTH   = 32,
    parameter int INDEX_WIDTH = 13,
    parameter int LIST_LEN    = 8192,
    parameter     FILE        = ""
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_start,
    input  logic                                i_wr_en,
    input  logic [$clog2(LIST_LEN)-1:0]         i_wr_addr,
    input  logic [INT_WIDTH+INDEX_WIDTH-1:0]    i_data_in,
    input  logic                                i_rd_en,
    input  logic [$clog2(LIST_LEN)-1:0]         i_rd_addr,
    output logic [INT_WIDTH+INDEX_WIDTH-1:0]    o_data_out,
    output logic                                o_fail,
    output logic                                o_done,
    output logic [1:0]                          o_state
);
    localparam int K  = $clog2(LIST_LEN);
    localparam int W  = INT_WIDTH + INDEX_WIDTH;
    localparam int PW = K + 1;
    localparam int RW = $clog2(K + 1);
    localparam logic [PW-1:0] LP_N        = PW'(LIST_LEN);
    localparam logic [RW-1:0] LP_LAST     = RW'(K - 1);
    localparam bit            LP_RES_IN_A = ((K % 2) == 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_MERGE = 2'd2
    } state_t;

    state_t        r_state, w_state_n;
    logic [RW-1:0] r_round, w_round_n;
    logic [PW-1:0] r_base, w_base_n;
    logic [PW-1:0] r_lptr, w_lptr_n;
    logic [PW-1:0] r_rptr, w_rptr_n;
    logic [PW-1:0] r_wptr, w_wptr_n;
    logic          r_fail, w_fail_n;
    logic          r_done, w_done_n;
    logic          r_rv, w_rv_n;

    logic [PW-1:0] w_run, w_lend, w_rend, w_wptr_inc;
    logic          w_lex, w_rex, w_src_a, w_running;
    logic          w_l_smaller, w_equal, w_take_l, w_collide, w_we;
    logic [W-1:0]  w_head_l, w_head_r, w_wdata;

    logic          w_a_en0, w_a_we0, w_a_en1, w_b_en0, w_b_we0, w_b_en1;
    logic [K-1:0]  w_a_addr0, w_a_addr1, w_b_addr0, w_b_addr1;
    logic [W-1:0]  w_a_wd0, w_b_wd0;
    logic [W-1:0]  w_qa0, w_qa1, w_qb0, w_qb1;

    assign w_running  = (r_state != S_IDLE);
    assign w_src_a    = ~r_round[0];
    assign w_run      = PW'(1) << r_round;
    assign w_lend     = r_base + w_run;
    assign w_rend     = r_base + (w_run << 1);
    assign w_lex      = (r_lptr == w_lend);
    assign w_rex      = (r_rptr == w_rend);
    assign w_wptr_inc = r_wptr + PW'(1);
    // Read addresses are driven from the next pointers, so the RAM outputs always hold the current heads.
    assign w_head_l   = w_src_a ? w_qa0 : w_qb0;
    assign w_head_r   = w_src_a ? w_qa1 : w_qb1;

    compare #(.KW(INT_WIDTH)) u_cmp (
        .i_key_l     (w_head_l[W-1:INDEX_WIDTH]),
        .i_key_r     (w_head_r[W-1:INDEX_WIDTH]),
        .o_l_smaller (w_l_smaller),
        .o_equal     (w_equal)
    );

    assign w_take_l  = !w_lex && (w_rex || w_l_smaller);
    assign w_collide = !w_lex && !w_rex && w_equal;
    assign w_wdata   = w_take_l ? w_head_l : w_head_r;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_round <= '0;
            r_base  <= '0;
            r_lptr  <= '0;
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_fail  <= 1'b0;
            r_done  <= 1'b0;
            r_rv    <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_round <= w_round_n;
            r_base  <= w_base_n;
            r_lptr  <= w_lptr_n;
            r_rptr  <= w_rptr_n;
            r_wptr  <= w_wptr_n;
            r_fail  <= w_fail_n;
            r_done  <= w_done_n;
            r_rv    <= w_rv_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_round_n = r_round;
        w_base_n  = r_base;
        w_lptr_n  = r_lptr;
        w_rptr_n  = r_rptr;
        w_wptr_n  = r_wptr;
        w_fail_n  = r_fail;
        w_done_n  = 1'b0;
        w_rv_n    = r_rv;
        w_we      = 1'b0;
        case (r_state)
            S_SETUP: w_state_n = S_MERGE;
            S_MERGE: begin
                if (w_collide) begin
                    w_fail_n  = 1'b1;
                    w_state_n = S_IDLE;
                end else begin
                    w_we     = 1'b1;
                    w_wptr_n = w_wptr_inc;
                    if (w_take_l) w_lptr_n = r_lptr + PW'(1);
                    else          w_rptr_n = r_rptr + PW'(1);
                    if (w_wptr_inc == w_rend) begin
                        if (w_rend == LP_N) begin
                            if (r_round == LP_LAST) begin
                                w_done_n  = 1'b1;
                                w_rv_n    = 1'b1;
                                w_state_n = S_IDLE;
                            end else begin
                                // The next round reads what was just written, so re-prime its heads.
                                w_round_n = r_round + RW'(1);
                                w_base_n  = '0;
                                w_lptr_n  = '0;
                                w_rptr_n  = w_run << 1;
                                w_wptr_n  = '0;
                                w_state_n = S_SETUP;
                            end
                        end else begin
                            w_base_n = w_rend;
                            w_lptr_n = w_rend;
                            w_rptr_n = w_rend + w_run;
                        end
                    end
                end
            end
            default: ;
        endcase
        if (i_start) begin
            w_state_n = S_SETUP;
            w_round_n = '0;
            w_base_n  = '0;
            w_lptr_n  = '0;
            w_rptr_n  = PW'(1);
            w_wptr_n  = '0;
            w_fail_n  = 1'b0;
            w_done_n  = 1'b0;
            w_rv_n    = 1'b0;
            w_we      = 1'b0;
        end
    end

    always_comb begin
        w_a_en0 = 1'b0; w_a_we0 = 1'b0; w_a_addr0 = '0; w_a_wd0 = '0;
        w_a_en1 = 1'b0; w_a_addr1 = '0;
        w_b_en0 = 1'b0; w_b_we0 = 1'b0; w_b_addr0 = '0; w_b_wd0 = '0;
        w_b_en1 = 1'b0; w_b_addr1 = '0;
        if (!w_running) begin
            w_a_we0   = i_wr_en;
            w_a_wd0   = i_data_in;
            w_a_addr0 = i_wr_en ? i_wr_addr : i_rd_addr;
            w_a_en0   = LP_RES_IN_A && i_rd_en && r_rv;
            w_b_addr0 = i_rd_addr;
            w_b_en0   = !LP_RES_IN_A && i_rd_en && r_rv;
        end else if (w_src_a) begin
            w_a_en0   = 1'b1;
            w_a_addr0 = w_lptr_n[K-1:0];
            w_a_en1   = 1'b1;
            w_a_addr1 = w_rptr_n[K-1:0];
            w_b_we0   = w_we;
            w_b_addr0 = r_wptr[K-1:0];
            w_b_wd0   = w_wdata;
        end else begin
            w_b_en0   = 1'b1;
            w_b_addr0 = w_lptr_n[K-1:0];
            w_b_en1   = 1'b1;
            w_b_addr1 = w_rptr_n[K-1:0];
            w_a_we0   = w_we;
            w_a_addr0 = r_wptr[K-1:0];
            w_a_wd0   = w_wdata;
        end
    end

    mem_dual #(.W(W), .DEPTH(LIST_LEN), .AW(K)) u_mem_a (
        .i_clk(i_clk),
        .i_en0(w_a_en0), .i_we0(w_a_we0), .i_addr0(w_a_addr0), .i_wdata0(w_a_wd0), .o_q0(w_qa0),
        .i_en1(w_a_en1), .i_we1(1'b0), .i_addr1(w_a_addr1), .i_wdata1('0), .o_q1(w_qa1)
    );

    mem_dual #(.W(W), .DEPTH(LIST_LEN), .AW(K)) u_mem_b (
        .i_clk(i_clk),
        .i_en0(w_b_en0), .i_we0(w_b_we0), .i_addr0(w_b_addr0), .i_wdata0(w_b_wd0), .o_q0(w_qb0),
        .i_en1(w_b_en1), .i_we1(1'b0), .i_addr1(w_b_addr1), .i_wdata1('0), .o_q1(w_qb1)
    );

    assign o_data_out = LP_RES_IN_A ? w_qa0 : w_qb0;
    assign o_fail     = r_fail;
    assign o_done     = r_done;
    assign o_state    = r_state;
endmodule

// File: tb/tb_pipelined_merge_sorter.sv
// Bench for pipelined_merge_sorter: three instances (8, 16, 32 entries) checked against a queue-sort model.
// Inputs change on the falling edge; outputs are sampled on the falling edge.

module tb_pipelined_merge_sorter;
    localparam int W  = 45;
    localparam int IW = 13;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [2:0]          start, wr_en, rd_en, done, fail;
    logic [2:0][4:0]     wr_addr, rd_addr;
    logic [2:0][W-1:0]   data_in, data_out;
    logic [2:0][1:0]     state;

    int checks = 0;
    int failures = 0;
    int done_cnt[3] = '{0, 0, 0};
    logic [31:0] ld_key[32];
    logic [W-1:0] exp_q[$];

    pipelined_merge_sorter #(.LIST_LEN(8)) u_dut8 (
        .i_clk(clk), .i_rst(rst), .i_start(start[0]), .i_wr_en(wr_en[0]),
        .i_wr_addr(wr_addr[0][2:0]), .i_data_in(data_in[0]), .i_rd_en(rd_en[0]),
        .i_rd_addr(rd_addr[0][2:0]), .o_data_out(data_out[0]), .o_fail(fail[0]),
        .o_done(done[0]), .o_state(state[0])
    );
    pipelined_merge_sorter #(.LIST_LEN(16)) u_dut16 (
        .i_clk(clk), .i_rst(rst), .i_start(start[1]), .i_wr_en(wr_en[1]),
        .i_wr_addr(wr_addr[1][3:0]), .i_data_in(data_in[1]), .i_rd_en(rd_en[1]),
        .i_rd_addr(rd_addr[1][3:0]), .o_data_out(data_out[1]), .o_fail(fail[1]),
        .o_done(done[1]), .o_state(state[1])
    );
    pipelined_merge_sorter #(.LIST_LEN(32)) u_dut32 (
        .i_clk(clk), .i_rst(rst), .i_start(start[2]), .i_wr_en(wr_en[2]),
        .i_wr_addr(wr_addr[2][4:0]), .i_data_in(data_in[2]), .i_rd_en(rd_en[2]),
        .i_rd_addr(rd_addr[2][4:0]), .o_data_out(data_out[2]), .o_fail(fail[2]),
        .o_done(done[2]), .o_state(state[2])
    );

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++)
            if (done[d] === 1'b1) done_cnt[d] <= done_cnt[d] + 1;
    end

    task automatic load_list(input int d);
        int n;
        n = 8 << d;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_en[d]   = 1'b1;
            wr_addr[d] = 5'(i);
            data_in[d] = {ld_key[i], 13'(i)};
        end
        @(negedge clk);
        wr_en[d] = 1'b0;
    endtask

    // Reference: entries are {key, index}; with distinct keys a full-word sort is a key sort.
    task automatic build_model(input int d);
        int n;
        n = 8 << d;
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back({ld_key[i], 13'(i)});
        exp_q.sort();
    endtask

    task automatic gen_keys(input int d);
        bit used[logic [31:0]];
        logic [31:0] kv;
        for (int i = 0; i < (8 << d); i++) begin
            do kv = $urandom; while (used.exists(kv));
            used[kv] = 1'b1;
            ld_key[i] = kv;
        end
    endtask

    task automatic run_sort(input int d, input bit junk, input bit expect_fail, input string name);
        int n, k, bound, cyc, d0;
        bit seen_done, seen_fail;
        n = 8 << d;
        k = 3 + d;
        bound = (k + 6) * n + 16 * k;
        d0 = done_cnt[d];
        seen_done = 1'b0;
        seen_fail = 1'b0;
        @(negedge clk);
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        checks++;
        if (fail[d] !== 1'b0) begin
            failures++;
            $display("FAIL %s_fail_clear got=%b exp=0", name, fail[d]);
        end
        cyc = 1;
        while (!seen_done && !seen_fail && cyc < bound) begin
            if (junk) begin
                wr_en[d]   = 1'b1;
                wr_addr[d] = 5'($urandom_range(0, n - 1));
                data_in[d] = {$urandom, 13'h1fff};
            end
            @(negedge clk);
            cyc++;
            seen_done = (done[d] === 1'b1);
            seen_fail = (fail[d] === 1'b1);
        end
        wr_en[d] = 1'b0;
        if (expect_fail) begin
            checks++;
            if (!seen_fail) begin
                failures++;
                $display("FAIL %s_fail_seen got=0 exp=1 within %0d cycles", name, bound);
            end
            repeat (10) @(negedge clk);
            checks++;
            if (fail[d] !== 1'b1) begin
                failures++;
                $display("FAIL %s_fail_sticky got=%b exp=1", name, fail[d]);
            end
            checks++;
            if (done_cnt[d] != d0) begin
                failures++;
                $display("FAIL %s_no_done got=%0d pulses exp=0", name, done_cnt[d] - d0);
            end
        end else begin
            checks++;
            if (!seen_done || cyc > bound) begin
                failures++;
                $display("FAIL %s_done_latency got=%0d cycles (done=%b) exp<=%0d", name, cyc, seen_done, bound);
            end
            checks++;
            if (fail[d] !== 1'b0) begin
                failures++;
                $display("FAIL %s_fail_low got=%b exp=0", name, fail[d]);
            end
            @(negedge clk);
            checks++;
            if (done[d] !== 1'b0) begin
                failures++;
                $display("FAIL %s_done_width got=%b exp=0 one cycle after done", name, done[d]);
            end
            checks++;
            if (done_cnt[d] - d0 != 1) begin
                failures++;
                $display("FAIL %s_done_count got=%0d exp=1", name, done_cnt[d] - d0);
            end
        end
    endtask

    // Back-to-back reads, sequential or in a random permutation of addresses.
    task automatic read_check(input int d, input bit shuffled, input string name);
        int n, j2, tmp;
        int order[32];
        n = 8 << d;
        for (int i = 0; i < n; i++) order[i] = i;
        if (shuffled) begin
            for (int i = n - 1; i > 0; i--) begin
                j2 = $urandom_range(0, i);
                tmp = order[i]; order[i] = order[j2]; order[j2] = tmp;
            end
        end
        for (int j = 0; j <= n; j++) begin
            @(negedge clk);
            if (j > 0) begin
                checks++;
                if (data_out[d] !== exp_q[order[j-1]]) begin
                    failures++;
                    $display("FAIL %s_rd addr=%0d got key=%0d idx=%0d exp key=%0d idx=%0d", name,
                             order[j-1], data_out[d][W-1:IW], data_out[d][IW-1:0],
                             exp_q[order[j-1]][W-1:IW], exp_q[order[j-1]][IW-1:0]);
                end
            end
            if (j < n) begin
                rd_en[d]   = 1'b1;
                rd_addr[d] = 5'(order[j]);
            end else begin
                rd_en[d] = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 3'b111;
        repeat (3) @(negedge clk);
        start = 3'b000;
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (done[d] !== 1'b0 || fail[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset_outputs dut=%0d got done=%b fail=%b exp done=0 fail=0", d, done[d], fail[d]);
            end
        end
        repeat (40) @(negedge clk);
        checks++;
        if (done_cnt[0] + done_cnt[1] + done_cnt[2] != 0) begin
            failures++;
            $display("FAIL reset_no_run got=%0d done pulses exp=0", done_cnt[0] + done_cnt[1] + done_cnt[2]);
        end
    endtask

    task automatic test_example();
        logic [31:0] keys[8] = '{5, 3, 7, 1, 8, 2, 6, 4};
        int idx_tbl[8] = '{3, 5, 1, 7, 0, 6, 2, 4};
        for (int i = 0; i < 8; i++) ld_key[i] = keys[i];
        load_list(0);
        run_sort(0, 1'b0, 1'b0, "example");
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back({32'(i + 1), 13'(idx_tbl[i])});
        read_check(0, 1'b0, "example");
    endtask

    task automatic test_sorted_reverse();
        for (int i = 0; i < 8; i++) ld_key[i] = 32'(10 * (i + 1));
        load_list(0);
        build_model(0);
        run_sort(0, 1'b0, 1'b0, "sorted");
        read_check(0, 1'b0, "sorted");
        for (int i = 0; i < 8; i++) ld_key[i] = 32'hffff_fff0 - 32'(i);
        load_list(0);
        build_model(0);
        run_sort(0, 1'b0, 1'b0, "reverse");
        read_check(0, 1'b0, "reverse");
    endtask

    task automatic test_duplicate();
        logic [31:0] dup[8]  = '{4, 1, 9, 3, 5, 2, 9, 7};
        logic [31:0] good[8] = '{4, 1, 9, 3, 5, 2, 8, 7};
        for (int i = 0; i < 8; i++) ld_key[i] = dup[i];
        load_list(0);
        run_sort(0, 1'b0, 1'b1, "dup");
        for (int i = 0; i < 8; i++) ld_key[i] = good[i];
        load_list(0);
        build_model(0);
        run_sort(0, 1'b0, 1'b0, "dup_reload");
        read_check(0, 1'b0, "dup_reload");
    endtask

    task automatic test_reset_mid();
        int d0;
        gen_keys(0);
        load_list(0);
        d0 = done_cnt[0];
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (done[0] !== 1'b0 || fail[0] !== 1'b0) begin
            failures++;
            $display("FAIL midrst_outputs got done=%b fail=%b exp done=0 fail=0", done[0], fail[0]);
        end
        repeat (60) @(negedge clk);
        checks++;
        if (done_cnt[0] != d0) begin
            failures++;
            $display("FAIL midrst_no_done got=%0d pulses exp=0", done_cnt[0] - d0);
        end
        load_list(0);
        build_model(0);
        run_sort(0, 1'b0, 1'b0, "midrst_reload");
        read_check(0, 1'b0, "midrst_reload");
    endtask

    task automatic test_read_latency();
        gen_keys(0);
        load_list(0);
        build_model(0);
        run_sort(0, 1'b0, 1'b0, "rdlat");
        @(negedge clk);
        rd_en[0]   = 1'b1;
        rd_addr[0] = 5'd0;
        @(negedge clk);
        rd_en[0] = 1'b0;
        checks++;
        if (data_out[0] !== exp_q[0]) begin
            failures++;
            $display("FAIL rdlat_addr0 got=%h exp=%h", data_out[0], exp_q[0]);
        end
        read_check(0, 1'b1, "rdlat_shuffle");
    endtask

    task automatic test_random(input int d, input bit junk, input string name);
        gen_keys(d);
        load_list(d);
        build_model(d);
        run_sort(d, junk, 1'b0, name);
        read_check(d, 1'b1, name);
    endtask

    initial begin
        rst = 1'b1;
        start = '0; wr_en = '0; rd_en = '0;
        wr_addr = '0; rd_addr = '0; data_in = '0;
        test_reset();
        test_example();
        test_sorted_reverse();
        test_duplicate();
        test_reset_mid();
        test_read_latency();
        test_random(1, 1'b1, "rand16");
        test_random(2, 1'b0, "rand32");
        test_random(2, 1'b1, "rand32_junk");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end
endmodule
